// File: rtl/dram_timing_pkg.sv
// Shared definitions for the multi-bank DRAM timing FSM: command codes, bank and
// burst-pipeline state encodings, default timings and counter sizing helpers.
package dram_timing_pkg;

  localparam logic [2:0] CmdNop  = 3'd0;
  localparam logic [2:0] CmdAct  = 3'd1;
  localparam logic [2:0] CmdRd   = 3'd2;
  localparam logic [2:0] CmdWr   = 3'd3;
  localparam logic [2:0] CmdPre  = 3'd4;
  localparam logic [2:0] CmdPrea = 3'd5;

  typedef enum logic [2:0] {
    BankIdle        = 3'd0,
    BankActivating  = 3'd1,
    BankActive      = 3'd2,
    BankReading     = 3'd3,
    BankWriting     = 3'd4,
    BankPrecharging = 3'd5
  } bank_state_e;

  typedef enum logic [1:0] {
    PipeIdle,
    PipeDelay,
    PipeBurst
  } pipe_state_e;

  localparam int unsigned DefNbanks = 4;
  localparam int unsigned DefRows   = 131072;
  localparam int unsigned DefBl     = 8;
  localparam int unsigned DefTrcd   = 3;
  localparam int unsigned DefTras   = 8;
  localparam int unsigned DefTrp    = 3;
  localparam int unsigned DefTcl    = 4;
  localparam int unsigned DefTcwl   = 3;

  // Width of a counter that must hold 0..max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of an index over n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: state, ACT/PRE delay timer, saturating tRAS counter and latched row.
// Command strobes arrive already checked for legality by the top level.
module dram_bank_fsm
  import dram_timing_pkg::*;
#(
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned TRCD = DefTrcd,
  parameter int unsigned TRAS = DefTras,
  parameter int unsigned TRP  = DefTrp
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       act,
  input  logic                       rd,
  input  logic                       wr,
  input  logic                       pre,
  input  logic                       burst_done,
  input  logic [idx_width(ROWS)-1:0] row,
  output bank_state_e                state,
  output logic [idx_width(ROWS)-1:0] open_row,
  output logic                       tras_met
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned TW = cnt_width((TRCD > TRP) ? TRCD : TRP);
  localparam int unsigned SW = cnt_width(TRAS);
  // Timers load delay-2: the transition edge itself is the last counted cycle.
  localparam logic [TW-1:0] ActLoad = TW'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [TW-1:0] PreLoad = TW'((TRP > 1) ? TRP - 2 : 0);
  localparam logic [SW-1:0] RasSat  = SW'(TRAS);

  bank_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] ras_q;
  logic [RW-1:0] row_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BankIdle;
      timer_q <= '0;
      ras_q   <= '0;
      row_q   <= '0;
    end else if (!halt) begin
      if (ras_q != RasSat) ras_q <= ras_q + 1'b1;
      unique case (state_q)
        BankIdle: begin
          if (act) begin
            row_q <= row;
            // The ACT edge itself counts as the first elapsed tRAS cycle.
            ras_q <= SW'(1);
            if (TRCD == 1) begin
              state_q <= BankActive;
            end else begin
              state_q <= BankActivating;
              timer_q <= ActLoad;
            end
          end
        end
        BankActivating: begin
          if (timer_q == '0) state_q <= BankActive;
          else timer_q <= timer_q - 1'b1;
        end
        BankActive: begin
          if (rd) begin
            state_q <= BankReading;
          end else if (wr) begin
            state_q <= BankWriting;
          end else if (pre) begin
            if (TRP == 1) begin
              state_q <= BankIdle;
            end else begin
              state_q <= BankPrecharging;
              timer_q <= PreLoad;
            end
          end
        end
        BankReading, BankWriting: begin
          if (burst_done) state_q <= BankActive;
        end
        BankPrecharging: begin
          if (timer_q == '0) state_q <= BankIdle;
          else timer_q <= timer_q - 1'b1;
        end
        default: state_q <= BankIdle;
      endcase
    end
  end

  assign state    = state_q;
  assign open_row = row_q;
  assign tras_met = (ras_q == RasSat);

endmodule

// File: rtl/dram_multibank_timing_fsm.sv
// Multi-bank DRAM timing checker: validates the command stream against per-bank state
// and drives the single shared read/write data-burst pipeline.
module dram_multibank_timing_fsm
  import dram_timing_pkg::*;
#(
  parameter int unsigned NBANKS = DefNbanks,
  parameter int unsigned ROWS   = DefRows,
  parameter int unsigned BL     = DefBl,
  parameter int unsigned TRCD   = DefTrcd,
  parameter int unsigned TRAS   = DefTras,
  parameter int unsigned TRP    = DefTrp,
  parameter int unsigned TCL    = DefTcl,
  parameter int unsigned TCWL   = DefTcwl
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                halt,
  input  logic                                cmd_valid,
  input  logic [2:0]                          cmd,
  input  logic [idx_width(NBANKS)-1:0]        cmd_bank,
  input  logic [idx_width(ROWS)-1:0]          cmd_row,
  output logic                                cmd_accept,
  output logic                                cmd_error,
  output logic [3*NBANKS-1:0]                 bank_state,
  output logic [idx_width(ROWS)*NBANKS-1:0]   open_row,
  output logic                                rd_valid,
  output logic                                wr_window,
  output logic [idx_width(NBANKS)-1:0]        burst_bank,
  output logic [idx_width(BL)-1:0]            burst_idx
);

  localparam int unsigned BW = idx_width(NBANKS);
  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned IW = idx_width(BL);
  localparam int unsigned DW = cnt_width((TCL > TCWL) ? TCL : TCWL);
  localparam logic [DW-1:0] RdLoad  = DW'((TCL > 1) ? TCL - 2 : 0);
  localparam logic [DW-1:0] WrLoad  = DW'((TCWL > 1) ? TCWL - 2 : 0);
  localparam logic [IW-1:0] LastIdx = IW'(BL - 1);

  bank_state_e       st [NBANKS];
  logic [NBANKS-1:0] tras_met, act_s, rd_s, wr_s, pre_s, done_s;

  pipe_state_e   phase_q;
  logic [DW-1:0] dly_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] owner_q;
  logic          is_wr_q, accept_q, error_q;

  logic        sample, legal, prea_ok, pipe_idle, start_rd, start_wr, burst_done, hit;
  bank_state_e tgt;

  // Legality is judged purely on pre-edge state so same-edge timer expiry never helps.
  always_comb begin
    sample    = cmd_valid && !halt && (cmd != CmdNop);
    pipe_idle = (phase_q == PipeIdle);
    tgt       = st[cmd_bank];
    prea_ok   = 1'b1;
    for (int i = 0; i < NBANKS; i++) begin
      if (!(st[i] == BankIdle || (st[i] == BankActive && tras_met[i]))) prea_ok = 1'b0;
    end
    case (cmd)
      CmdAct:        legal = (tgt == BankIdle);
      CmdRd, CmdWr:  legal = (tgt == BankActive) && pipe_idle;
      CmdPre:        legal = (tgt == BankIdle) || (tgt == BankActive && tras_met[cmd_bank]);
      CmdPrea:       legal = prea_ok;
      default:       legal = 1'b0;
    endcase
    start_rd   = sample && legal && (cmd == CmdRd);
    start_wr   = sample && legal && (cmd == CmdWr);
    burst_done = !halt && (phase_q == PipeBurst) && (idx_q == LastIdx);
    for (int i = 0; i < NBANKS; i++) begin
      hit       = (cmd_bank == BW'(i));
      act_s[i]  = sample && legal && (cmd == CmdAct) && hit;
      rd_s[i]   = start_rd && hit;
      wr_s[i]   = start_wr && hit;
      // PRE to an idle bank is accepted but leaves it untouched.
      pre_s[i]  = sample && legal && (st[i] == BankActive) &&
                  (((cmd == CmdPre) && hit) || (cmd == CmdPrea));
      done_s[i] = burst_done && (owner_q == BW'(i));
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    dram_bank_fsm #(
      .ROWS(ROWS),
      .TRCD(TRCD),
      .TRAS(TRAS),
      .TRP (TRP)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .act       (act_s[g]),
      .rd        (rd_s[g]),
      .wr        (wr_s[g]),
      .pre       (pre_s[g]),
      .burst_done(done_s[g]),
      .row       (cmd_row),
      .state     (st[g]),
      .open_row  (open_row[g*RW +: RW]),
      .tras_met  (tras_met[g])
    );
    assign bank_state[g*3 +: 3] = st[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PipeIdle;
      dly_q    <= '0;
      idx_q    <= '0;
      owner_q  <= '0;
      is_wr_q  <= 1'b0;
      accept_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      accept_q <= sample && legal;
      error_q  <= sample && !legal;
      if (!halt) begin
        unique case (phase_q)
          PipeIdle: begin
            if (start_rd || start_wr) begin
              owner_q <= cmd_bank;
              is_wr_q <= start_wr;
              idx_q   <= '0;
              if ((start_wr ? TCWL : TCL) == 1) begin
                phase_q <= PipeBurst;
              end else begin
                phase_q <= PipeDelay;
                dly_q   <= start_wr ? WrLoad : RdLoad;
              end
            end
          end
          PipeDelay: begin
            if (dly_q == '0) phase_q <= PipeBurst;
            else dly_q <= dly_q - 1'b1;
          end
          PipeBurst: begin
            if (idx_q == LastIdx) begin
              phase_q <= PipeIdle;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          default: phase_q <= PipeIdle;
        endcase
      end
    end
  end

  // Beats are masked while halted; the frozen beat counter replays them afterwards.
  assign rd_valid   = (phase_q == PipeBurst) && !is_wr_q && !halt;
  assign wr_window  = (phase_q == PipeBurst) && is_wr_q && !halt;
  assign cmd_accept = accept_q;
  assign cmd_error  = error_q;
  assign burst_bank = owner_q;
  assign burst_idx  = idx_q;

endmodule
